// File: rtl/buffer_slot_alloc_if.sv
// Shared sizing for the sort buffer, plus the allocate/release handshake bundle.
// Latency: none (wires only).
// Backpressure: alloc side is valid/ready; the release side is fire-and-forget.

package conf_pkg;
    localparam int BUFFER_DEPTH = 8;
    typedef logic [2:0] buffer_pointer_t;
endpackage

interface buffer_slot_alloc_if #(
    parameter int DEPTH = conf_pkg::BUFFER_DEPTH,
    parameter int PTR_W = $bits(conf_pkg::buffer_pointer_t)
);
    // Allocation handshake: allocator offers, write path takes.
    logic             alloc_valid;
    logic             alloc_ready;
    logic [PTR_W-1:0] alloc_index;

    // Release request from the drain path.
    logic             free_valid;
    logic [PTR_W-1:0] free_index;

    // Write path / drain path side.
    modport master (
        input  alloc_valid,
        input  alloc_index,
        output alloc_ready,
        output free_valid,
        output free_index
    );

    // Allocator side.
    modport slave (
        output alloc_valid,
        output alloc_index,
        input  alloc_ready,
        input  free_valid,
        input  free_index
    );
endinterface

// File: rtl/buffer_slot_alloc.sv
// Slot allocator: hands out the lowest free slot and accepts releases by index.
// Latency: alloc/free update occupancy and count at the sampling edge, visible next cycle.
// Backpressure: alloc_valid drops while full; alloc_ready without alloc_valid is ignored.
// Optional macro SLOT_ALLOC_CHECK_EN builds the registered free_error pulse.

module buffer_slot_alloc #(
    parameter int DEPTH = conf_pkg::BUFFER_DEPTH,
    parameter int PTR_W = $bits(conf_pkg::buffer_pointer_t),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    buffer_slot_alloc_if.slave   bus,
    output logic [DEPTH-1:0]     occupancy,
    output logic [CNT_W-1:0]     count,
    output logic                 full,
    output logic                 empty,
    output logic                 free_error
);

    logic [DEPTH-1:0] occ_q, occ_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [PTR_W-1:0] search_idx;
    logic             search_hit;
    logic             alloc_fire;
    logic [DEPTH-1:0] alloc_set;
    logic [DEPTH-1:0] free_dec;
    logic [DEPTH-1:0] free_clr;
    logic             free_legal;

    // Lowest-zero search across every slot, top bit included; index 0 when nothing is free.
    always_comb begin
        search_idx = '0;
        search_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!search_hit && !occ_q[i]) begin
                search_idx = PTR_W'(i);
                search_hit = 1'b1;
            end
        end
    end

    assign alloc_fire = search_hit && bus.alloc_ready;

    // One-hot set mask for the slot being handed out this cycle.
    always_comb begin
        alloc_set = '0;
        for (int i = 0; i < DEPTH; i++) begin
            alloc_set[i] = alloc_fire && (search_idx == PTR_W'(i));
        end
    end

    // One-hot decode of the release index; indices at or beyond DEPTH match no slot,
    // so they are masked rather than folded onto a low slot.
    always_comb begin
        free_dec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            free_dec[i] = bus.free_valid && (bus.free_index == PTR_W'(i));
        end
    end

    // Only an occupied slot may be released; anything else leaves state alone.
    assign free_clr   = free_dec & occ_q;
    assign free_legal = |free_clr;

    // Next-state: flush wins, otherwise apply alloc set and legal clear together.
    always_comb begin
        occ_d   = occ_q;
        count_d = count_q;
        if (flush) begin
            occ_d   = '0;
            count_d = '0;
        end else begin
            // The alloc slot is free by construction, so set and clear never collide.
            occ_d = (occ_q | alloc_set) & ~free_clr;
            case ({alloc_fire, free_legal})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Occupancy and count registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q   <= '0;
            count_q <= '0;
        end else begin
            occ_q   <= occ_d;
            count_q <= count_d;
        end
    end

`ifdef SLOT_ALLOC_CHECK_EN
    logic free_error_q, free_error_d;

    // A release is flagged when it hits no occupied slot; flush discards the release.
    assign free_error_d = !flush && bus.free_valid && !free_legal;

    // One-cycle error pulse per illegal release, registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            free_error_q <= 1'b0;
        end else begin
            free_error_q <= free_error_d;
        end
    end

    assign free_error = free_error_q;
`else
    assign free_error = 1'b0;
`endif

    assign bus.alloc_valid = search_hit;
    assign bus.alloc_index = search_idx;
    assign occupancy       = occ_q;
    assign count           = count_q;
    assign full            = (count_q == CNT_W'(DEPTH));
    assign empty           = (count_q == '0);

endmodule

// File: tb/tb_buffer_slot_alloc.sv
// Bench for buffer_slot_alloc: vector table with a scoreboard queue, plus reset corner cases.
// Latency: each vector's expectation is compared 1 ns after the edge that samples it.
// Backpressure: alloc_ready and free requests are driven directly from the table.

module tb_buffer_slot_alloc;

    localparam int DEPTH = 8;
    localparam int PTR_W = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct {
        logic             flush;
        logic             rdy;
        logic             fv;
        logic [PTR_W-1:0] fidx;
        logic [DEPTH-1:0] exp_occ;
        logic             illegal;
    } vec_t;

    typedef struct {
        logic [DEPTH-1:0] occ;
        logic             err;
        int               id;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             flush;
    logic [DEPTH-1:0] occupancy;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             free_error;

    int n_checks = 0;
    int n_errors = 0;

    vec_t vecs[$];
    exp_t sb[$];

    buffer_slot_alloc_if #(.DEPTH(DEPTH), .PTR_W(PTR_W)) bus ();

    buffer_slot_alloc #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .bus        (bus),
        .occupancy  (occupancy),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .free_error (free_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Count must track popcount(occupancy) on every cycle.
    always @(negedge clk) begin
        check("count_popcount", 32'(count), 32'($countones(occupancy)));
    end

    task automatic add(input logic f, input logic r, input logic fv, input int fi,
                       input logic [DEPTH-1:0] occ, input logic ill);
        vec_t v;
        v.flush   = f;
        v.rdy     = r;
        v.fv      = fv;
        v.fidx    = PTR_W'(fi);
        v.exp_occ = occ;
        v.illegal = ill;
        vecs.push_back(v);
    endtask

    function automatic int lowest_free(input logic [DEPTH-1:0] occ);
        int k;
        k = 0;
        while (k < DEPTH && occ[k]) k++;
        return (k == DEPTH) ? 0 : k;
    endfunction

    task automatic push_exp(input logic [DEPTH-1:0] occ, input logic ill, input int id);
        exp_t e;
        e.occ = occ;
`ifdef SLOT_ALLOC_CHECK_EN
        e.err = ill;
`else
        e.err = 1'b0;
`endif
        e.id = id;
        sb.push_back(e);
    endtask

    // Pop the oldest expectation and compare every registered output against it.
    task automatic compare_out();
        exp_t e;
        string tag;
        if (sb.size() == 0) begin
            check("scoreboard_nonempty", 32'(0), 32'(1));
            return;
        end
        e = sb.pop_front();
        tag = $sformatf("v%0d", e.id);
        check({tag, "_occupancy"},   32'(occupancy),      32'(e.occ));
        check({tag, "_count"},       32'(count),          32'($countones(e.occ)));
        check({tag, "_full"},        32'(full),           32'(e.occ == '1));
        check({tag, "_empty"},       32'(empty),          32'(e.occ == '0));
        check({tag, "_alloc_valid"}, 32'(bus.alloc_valid), 32'(e.occ != '1));
        check({tag, "_alloc_index"}, 32'(bus.alloc_index), 32'(lowest_free(e.occ)));
        check({tag, "_free_error"},  32'(free_error),     32'(e.err));
    endtask

    task automatic drive_idle();
        flush           = 1'b0;
        bus.alloc_ready = 1'b0;
        bus.free_valid  = 1'b0;
        bus.free_index  = '0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_occupancy"},   32'(occupancy),       32'(0));
        check({tag, "_count"},       32'(count),           32'(0));
        check({tag, "_empty"},       32'(empty),           32'(1));
        check({tag, "_full"},        32'(full),            32'(0));
        check({tag, "_alloc_valid"}, 32'(bus.alloc_valid), 32'(1));
        check({tag, "_alloc_index"}, 32'(bus.alloc_index), 32'(0));
        check({tag, "_free_error"},  32'(free_error),      32'(0));
    endtask

    initial begin
        // flush, alloc_ready, free_valid, free_index, occupancy after the edge, illegal free
        add(0, 1, 0, 0, 8'h01, 0);
        add(0, 1, 0, 0, 8'h03, 0);
        add(0, 1, 0, 0, 8'h07, 0);
        add(0, 1, 0, 0, 8'h0F, 0);
        add(0, 1, 0, 0, 8'h1F, 0);
        add(0, 1, 0, 0, 8'h3F, 0);
        add(0, 1, 0, 0, 8'h7F, 0);
        add(0, 1, 0, 0, 8'hFF, 0);  // last slot filled
        add(0, 1, 0, 0, 8'hFF, 0);  // ready while full: ignored
        add(0, 1, 1, 3, 8'hF7, 0);  // free 3 from full; freed slot not reused same cycle
        add(0, 1, 0, 0, 8'hFF, 0);  // slot 3 reissued
        add(0, 0, 1, 7, 8'h7F, 0);  // top slot freed alone
        add(0, 1, 1, 0, 8'hFE, 0);  // alloc 7 with free 0: full stays low
        add(0, 1, 0, 0, 8'hFF, 0);
        add(1, 1, 1, 2, 8'h00, 0);  // flush beats alloc and free
        add(0, 1, 0, 0, 8'h01, 0);
        add(0, 1, 0, 0, 8'h03, 0);
        add(0, 1, 0, 0, 8'h07, 0);
        add(0, 0, 1, 1, 8'h05, 0);
        add(0, 1, 1, 2, 8'h03, 0);  // alloc 1 with free 2, count stays 2
        add(0, 0, 1, 5, 8'h03, 1);  // free of empty slot
        add(0, 0, 0, 0, 8'h03, 0);  // pulse lasts one cycle
        add(0, 0, 1, 9, 8'h03, 1);  // out of range; low bits alias occupied slot 1
        add(0, 0, 1, 5, 8'h03, 1);  // back-to-back illegal frees
        add(0, 0, 1, 8, 8'h03, 1);  // out of range aliasing slot 0
        add(0, 0, 0, 0, 8'h03, 0);
        add(0, 1, 1, 0, 8'h06, 0);  // alloc 2 with free 0
        add(1, 0, 1, 5, 8'h00, 0);  // flush discards the would-be illegal free
        add(0, 1, 0, 0, 8'h01, 0);
        add(0, 1, 0, 0, 8'h03, 0);
        add(0, 1, 0, 0, 8'h07, 0);
        add(0, 1, 0, 0, 8'h0F, 0);  // count = 4 for the mid-stream reset

        drive_idle();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_reset("reset");
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            flush           = vecs[i].flush;
            bus.alloc_ready = vecs[i].rdy;
            bus.free_valid  = vecs[i].fv;
            bus.free_index  = vecs[i].fidx;
            push_exp(vecs[i].exp_occ, vecs[i].fv && vecs[i].illegal, i);
            @(posedge clk);
            #1;
            compare_out();
        end

        // Asynchronous reset in the middle of an alloc handshake, between edges.
        check("pre_reset_count", 32'(count), 32'(4));
        bus.alloc_ready = 1'b1;
        #3;
        rst = 1'b1;
        #1;
        check_reset("async_reset");
        #2;
        rst = 1'b0;
        push_exp(8'h01, 1'b0, 100);
        @(posedge clk);
        #1;
        compare_out();

        drive_idle();
        @(posedge clk);
        #1;
        check("final_scoreboard_drained", 32'(sb.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/buffer_slot_alloc.md
# buffer_slot_alloc

Slot allocator for the sort buffer: tracks occupancy of `BUFFER_DEPTH` slots and hands out the lowest-numbered free slot on a valid/ready handshake. It also accepts slot releases by index, decoding each index into a one-hot clear of the occupancy vector. It sits between the buffer write path, which consumes `alloc_index`, and the drain path, which returns indices through the free port. Its `occupancy` vector is the set-bit vector the downstream priority search consumes.

## Interface
- `DEPTH`, default `BUFFER_DEPTH` (conf_pkg): number of slots; ≥ 2.
- `PTR_W`, default `$bits(buffer_pointer_t)`: index width; `2**PTR_W ≥ DEPTH`.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `flush` in 1: synchronous clear of all occupancy; has priority over alloc and free.
- `alloc_ready` in 1: consumer takes `alloc_index` this cycle.
- `alloc_valid` out 1: a free slot exists (`!full`).
- `alloc_index` out `PTR_W`: lowest-numbered free slot; 0 when `!alloc_valid`.
- `free_valid` in 1: release request.
- `free_index` in `PTR_W`: slot to release.
- `occupancy` out `DEPTH`: registered occupancy vector; bit i = slot i in use.
- `count` out `$clog2(DEPTH+1)`: number of occupied slots (registered).
- `full` out 1: `count == DEPTH`.
- `empty` out 1: `count == 0`.
- `free_error` out 1: registered one-cycle pulse for an illegal free (see Configuration).

## Operation
- State: `occupancy`, `count`, plus `free_error` when configured. No other FSM; each cycle is IDLE / ALLOC / FREE / ALLOC+FREE / FLUSH, decided from the inputs.
- `alloc_index` and `alloc_valid` are combinational from registered `occupancy`.
  - The search covers all `DEPTH` bits, including bit `DEPTH-1`.
  - Lowest zero bit wins.
- Alloc fire = `alloc_valid && alloc_ready`: sets `occupancy[alloc_index]` and increments `count`.
- Free is legal when `free_valid`, `free_index < DEPTH` and `occupancy[free_index] == 1`.
  - Legal free clears that bit (one-hot decode of `free_index`) and decrements `count`.
  - Illegal free leaves all state unchanged.
- Alloc and legal free in the same cycle: both apply and `count` is unchanged.
  - `free_index == alloc_index` is impossible when legal, because the alloc slot is by definition free.
- A slot freed in cycle N is not offered to alloc before cycle N+1.
- `alloc_ready` while `!alloc_valid` is ignored; no state change.
- `flush`: `occupancy ← 0`, `count ← 0`, `free_error ← 0`. Same-cycle alloc and free are discarded.
- `count` always equals popcount(`occupancy`); the bench checks this every cycle.

## Timing
- Reset (async assert, any cycle including mid-handshake):
  - `occupancy` = 0, `count` = 0, `empty` = 1, `full` = 0.
  - `alloc_valid` = 1, `alloc_index` = 0, `free_error` = 0.
- Alloc and free take effect at the edge where they are sampled. `occupancy`, `count`, `full`, `empty`, `alloc_index` and `alloc_valid` reflect the change in the next cycle (latency 1).
- Back-to-back allocs with `alloc_ready` held high yield slots 0,1,2,… on consecutive cycles; one slot per cycle max.
- Full boundary: the alloc that fills the last slot drops `alloc_valid` the next cycle. A same-cycle legal free keeps `full` = 0.
- `free_error` asserts the cycle after the illegal request, for exactly one cycle per illegal request.

## Configuration
- `SLOT_ALLOC_CHECK_EN` defined: `free_error` is generated. It pulses for a free of an unoccupied slot or for `free_index ≥ DEPTH`.
- `SLOT_ALLOC_CHECK_EN` undefined:
  - `free_error` is tied to 0 and no error register is built.
  - Illegal frees are still silently ignored, with no state change.
  - An out-of-range index is masked, never decoded.

## Test plan
- Reset then hold `alloc_ready`=1 for 8 cycles (DEPTH=8) -> indices 0..7 in order, `full`=1 and `alloc_valid`=0 on cycle 9, `count`=8.
- From full, free slot 3 -> next cycle `alloc_valid`=1, `alloc_index`=3, `count`=7. Free slot 7 alone from full -> `alloc_index`=7, which checks top-bit coverage.
- `occupancy`=0b0000_0101, alloc (index 1) with free 2 in the same cycle -> `occupancy`=0b0000_0011, `count` unchanged at 2.
- With `SLOT_ALLOC_CHECK_EN`: free an empty slot 5 and free index 9 -> two `free_error` pulses, `occupancy` unchanged. Without the macro -> `free_error` stays 0.
- `occupancy`=0xFF, assert `flush` with `alloc_ready` and `free_valid` high -> next cycle `occupancy`=0, `empty`=1, `alloc_index`=0.
- Assert `rst` asynchronously mid-stream with `count`=4 -> outputs reach reset values before the next edge. Deassert, then alloc -> index 0.
